alu_iter: RTL

// - Parametrised multi-cycle integer ALU for the suro-v core; successor to alu3, instantiated by the datapath.
// - Add/sub, compare, logic and branch compare complete in the start cycle. Shifts iterate SHIFT_STEP bits per cycle.
// - Exposes the remaining shift amount so the datapath can park it in r2.

---
 rtl/alu_iter_if.sv | 39 +++
 rtl/alu_iter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// Bus interface for alu_iter: request operands, result, remaining shift count and status.
// The optional shadd select exists only when ALU_SHADD_EN is defined.
interface alu_iter_if #(
    parameter int XLEN = 32
);
    localparam int SHW = $clog2(XLEN);

    logic            start;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [2:0]      f3;
    logic            arith_bit;
    logic            branch;
`ifdef ALU_SHADD_EN
    logic            shadd;
`endif
    logic [XLEN-1:0] out;
    logic [SHW-1:0]  shamt_out;
    logic            done;
    logic            busy;

    // Datapath side: issues requests and consumes results
    modport master (
`ifdef ALU_SHADD_EN
        output shadd,
`endif
        output start, src_a, src_b, f3, arith_bit, branch,
        input  out, shamt_out, done, busy
    );

    // ALU side
    modport slave (
`ifdef ALU_SHADD_EN
        input  shadd,
`endif
        input  start, src_a, src_b, f3, arith_bit, branch,
        output out, shamt_out, done, busy
    );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle integer ALU. Add/sub, compares, logic ops and branch compares
// resolve combinationally in IDLE; shifts iterate up to SHIFT_STEP bits per cycle in SHIFT.
// Optional feature macro: ALU_SHADD_EN adds the Zba shNadd select (bus.shadd).
module alu_iter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input logic         clk,
    input logic         rst,
    alu_iter_if.slave   bus
);
    localparam int SHW = $clog2(XLEN);
    // SHIFT_STEP may equal XLEN, so it needs one bit more than a shift amount
    localparam logic [SHW:0] STEP_MAX = (SHW + 1)'(SHIFT_STEP);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;
    logic            dir_left;
    logic            sra;

    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic            launch;
    logic [XLEN-1:0] comb_out;
    logic [SHW:0]    step;
    logic [XLEN-1:0] acc_next;

    assign shamt    = bus.src_b[SHW-1:0];
    assign is_shift = !bus.branch && (bus.f3 == 3'b001 || bus.f3 == 3'b101);
    assign launch   = bus.start && is_shift && (shamt != '0);

    // Single-cycle result for every non-iterating operation (and src_a for shifts)
    always_comb begin
        comb_out = '0;
        if (bus.branch) begin
            case (bus.f3)
                3'b000:  comb_out[0] = (bus.src_a == bus.src_b);
                3'b001:  comb_out[0] = (bus.src_a != bus.src_b);
                3'b100:  comb_out[0] = ($signed(bus.src_a) < $signed(bus.src_b));
                3'b101:  comb_out[0] = !($signed(bus.src_a) < $signed(bus.src_b));
                3'b110:  comb_out[0] = (bus.src_a < bus.src_b);
                3'b111:  comb_out[0] = !(bus.src_a < bus.src_b);
                default: comb_out    = '0;
            endcase
        end else begin
            case (bus.f3)
                3'b000:  comb_out    = bus.arith_bit ? (bus.src_a - bus.src_b) : (bus.src_a + bus.src_b);
                3'b001:  comb_out    = bus.src_a;
                3'b010:  comb_out[0] = ($signed(bus.src_a) < $signed(bus.src_b));
                3'b011:  comb_out[0] = (bus.src_a < bus.src_b);
                3'b100:  comb_out    = bus.src_a ^ bus.src_b;
                3'b101:  comb_out    = bus.src_a;
                3'b110:  comb_out    = bus.src_a | bus.src_b;
                default: comb_out    = bus.src_a & bus.src_b;
            endcase
        end
`ifdef ALU_SHADD_EN
        // shNadd overrides only for its three f3 codes; other f3 fall through unchanged
        if (bus.shadd) begin
            case (bus.f3)
                3'b010:  comb_out = (bus.src_a << 1) + bus.src_b;
                3'b100:  comb_out = (bus.src_a << 2) + bus.src_b;
                3'b110:  comb_out = (bus.src_a << 3) + bus.src_b;
                default: ;
            endcase
        end
`endif
    end

    // One shift iteration: move by min(cnt, SHIFT_STEP), arithmetic right fills with acc's sign
    always_comb begin
        step = ({1'b0, cnt} < STEP_MAX) ? {1'b0, cnt} : STEP_MAX;
        if (dir_left)
            acc_next = acc << step;
        else if (sra)
            acc_next = $unsigned($signed(acc) >>> step);
        else
            acc_next = acc >> step;
    end

    // Output mux: live combinational result in IDLE, accumulator and count while shifting
    always_comb begin
        bus.out       = comb_out;
        bus.shamt_out = is_shift ? shamt : '0;
        bus.done      = !launch;
        bus.busy      = 1'b0;
        if (state == SHIFT) begin
            bus.out       = acc;
            bus.shamt_out = cnt;
            bus.done      = (cnt == '0);
            bus.busy      = 1'b1;
        end
    end

    // FSM: launch a shift from IDLE, iterate until the count reaches zero, then return
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
            sra      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= SHIFT;
                        acc      <= bus.src_a;
                        cnt      <= shamt;
                        dir_left <= (bus.f3 == 3'b001);
                        sra      <= bus.arith_bit && (bus.f3 == 3'b101);
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - step[SHW-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
